ppu_stream_ctrl: RTL and testbench

Sequencer that drives the post-processing unit (PPU) and collects its results. Psums arrive as a valid/ready stream from the psum buffer. The block presents them to the PPU together with the maxpool and ReLU control strobes. It then samples the PPU's int8 result for each window, packs four results into a 32-bit word, and hands the word to the GLB write port over a valid/ready interface.

---
 rtl/ppu_stream_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ppu_stream_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_stream_ctrl.sv
// ppu_stream_ctrl: feeds psums from a valid/ready stream into the PPU and
// drives the maxpool/ReLU controls. It then collects one int8 result per
// pooling window, packs four results little-endian into a 32-bit word, and
// offers each word to the GLB write port over valid/ready.
module ppu_stream_ctrl #(
  parameter int MAX_OUT_W = 16,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           cfg_win_len,
  input  logic                 cfg_pool_en,
  input  logic                 cfg_relu_en,
  input  logic [5:0]           cfg_scale,
  input  logic [MAX_OUT_W-1:0] cfg_num_out,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] ppu_data_in,
  output logic [5:0]           ppu_scaling_factor,
  output logic                 ppu_maxpool_en,
  output logic                 ppu_maxpool_init,
  output logic                 ppu_relu_sel,
  output logic                 ppu_relu_en,
  input  logic [7:0]           ppu_data_out,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FEED = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_PUSH = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [MAX_OUT_W-1:0] CNT_ONE = 1;

  logic [2:0]           state_reg;
  logic [2:0]           win_len_reg;
  logic                 pool_en_reg;
  logic                 relu_en_reg;
  logic                 relu_sel_reg;
  logic [5:0]           scale_reg;
  logic [MAX_OUT_W-1:0] num_out_reg;
  logic [MAX_OUT_W-1:0] out_cnt_reg;
  logic [2:0]           elem_cnt_reg;
  logic [1:0]           byte_idx_reg;
  logic                 capt_wait_reg;
  logic [DATA_BITS-1:0] data_in_reg;
  logic                 mp_en_reg;
  logic                 mp_init_reg;

  logic in_fire;
  logic last_elem;
  logic sample_now;
  logic last_result;
  logic push_fire;
  logic job_start;
  logic [2:0] win_len_eff;

  assign in_fire     = (state_reg == S_FEED) && in_valid;
  assign last_elem   = (elem_cnt_reg == (win_len_reg - 3'd1));
  // Bypass is combinational through the PPU, so sample while the psum is
  // presented; pool must wait one more cycle for the comparator register.
  assign sample_now  = (state_reg == S_CAPT) && (!pool_en_reg || capt_wait_reg);
  assign last_result = ((out_cnt_reg + CNT_ONE) == num_out_reg);
  assign push_fire   = (state_reg == S_PUSH) && out_ready;
  assign job_start   = (state_reg == S_IDLE) && start;
  // A zero window length would never close a window; run it as length 1.
  assign win_len_eff = (cfg_win_len == 3'd0) ? 3'd1 : cfg_win_len;

  assign in_ready           = (state_reg == S_FEED);
  assign out_valid          = (state_reg == S_PUSH);
  assign busy               = (state_reg != S_IDLE);
  assign done               = (state_reg == S_DONE);
  assign ppu_data_in        = data_in_reg;
  assign ppu_maxpool_en     = mp_en_reg;
  assign ppu_maxpool_init   = mp_init_reg;
  assign ppu_scaling_factor = scale_reg;
  assign ppu_relu_en        = relu_en_reg;
  assign ppu_relu_sel       = relu_sel_reg;

  // Latch job configuration on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_len_reg  <= '0;
      pool_en_reg  <= 1'b0;
      relu_en_reg  <= 1'b0;
      relu_sel_reg <= 1'b0;
      scale_reg    <= '0;
      num_out_reg  <= '0;
    end else if (job_start) begin
      win_len_reg  <= win_len_eff;
      pool_en_reg  <= cfg_pool_en;
      relu_en_reg  <= cfg_relu_en;
      relu_sel_reg <= ~cfg_pool_en;
      scale_reg    <= cfg_scale;
      num_out_reg  <= cfg_num_out;
    end
  end

  // Sequencer state, window/result counters and capture sub-cycle flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      elem_cnt_reg  <= '0;
      byte_idx_reg  <= '0;
      out_cnt_reg   <= '0;
      capt_wait_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            elem_cnt_reg  <= '0;
            byte_idx_reg  <= '0;
            out_cnt_reg   <= '0;
            capt_wait_reg <= 1'b0;
            state_reg     <= (cfg_num_out == '0) ? S_DONE : S_FEED;
          end
        end
        S_FEED: begin
          if (in_fire) begin
            if (last_elem) begin
              elem_cnt_reg  <= '0;
              capt_wait_reg <= 1'b0;
              state_reg     <= S_CAPT;
            end else begin
              elem_cnt_reg <= elem_cnt_reg + 3'd1;
            end
          end
        end
        S_CAPT: begin
          if (sample_now) begin
            capt_wait_reg <= 1'b0;
            out_cnt_reg   <= out_cnt_reg + CNT_ONE;
            byte_idx_reg  <= byte_idx_reg + 2'd1;
            state_reg     <= ((byte_idx_reg == 2'd3) || last_result) ? S_PUSH : S_FEED;
          end else begin
            capt_wait_reg <= 1'b1;
          end
        end
        S_PUSH: begin
          if (out_ready) begin
            byte_idx_reg <= '0;
            state_reg    <= (out_cnt_reg == num_out_reg) ? S_DONE : S_FEED;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // PPU input register; maxpool strobes pulse only on an accepted psum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_in_reg <= '0;
      mp_en_reg   <= 1'b0;
      mp_init_reg <= 1'b0;
    end else begin
      mp_en_reg   <= 1'b0;
      mp_init_reg <= 1'b0;
      if (in_fire) begin
        data_in_reg <= in_data;
        mp_en_reg   <= pool_en_reg;
        mp_init_reg <= (elem_cnt_reg == 3'd0);
      end
    end
  end

  // One byte lane per result slot; lanes not written before a push stay 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Clear at job start and after each pushed word, load on its sample.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (job_start || push_fire) begin
          lane_reg <= '0;
        end else if (sample_now && (byte_idx_reg == 2'(gi))) begin
          lane_reg <= ppu_data_out;
        end
      end

      assign out_data[8*gi +: 8] = lane_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ppu_stream_ctrl.sv
// Testbench for ppu_stream_ctrl: a behavioural PPU (shift, saturate, ReLU,
// running max) closes the loop. Jobs come from a table of configurations,
// psums and expected packed words. Hand-written sequences cover input gaps,
// output backpressure and reset in the middle of a job.
module tb_ppu_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_win_len;
  logic        cfg_pool_en;
  logic        cfg_relu_en;
  logic [5:0]  cfg_scale;
  logic [15:0] cfg_num_out;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] ppu_data_in;
  logic [5:0]  ppu_scaling_factor;
  logic        ppu_maxpool_en;
  logic        ppu_maxpool_init;
  logic        ppu_relu_sel;
  logic        ppu_relu_en;
  logic [7:0]  ppu_data_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  ppu_stream_ctrl #(.MAX_OUT_W(16), .DATA_BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_win_len(cfg_win_len), .cfg_pool_en(cfg_pool_en),
    .cfg_relu_en(cfg_relu_en), .cfg_scale(cfg_scale), .cfg_num_out(cfg_num_out),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ppu_data_in(ppu_data_in), .ppu_scaling_factor(ppu_scaling_factor),
    .ppu_maxpool_en(ppu_maxpool_en), .ppu_maxpool_init(ppu_maxpool_init),
    .ppu_relu_sel(ppu_relu_sel), .ppu_relu_en(ppu_relu_en),
    .ppu_data_out(ppu_data_out), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PPU: arithmetic shift by the scale, saturate to int8,
  // optional ReLU, and a max register updated on maxpool_en.
  function automatic logic [7:0] quant(input logic [15:0] p, input logic [5:0] s);
    logic signed [15:0] sh;
    sh = $signed(p) >>> s;
    if (sh > 16'sd127) return 8'h7F;
    if (sh < -16'sd128) return 8'h80;
    return sh[7:0];
  endfunction

  logic [7:0] q_cur;
  logic [7:0] pool_reg;
  logic [7:0] mux_out;

  assign q_cur        = quant(ppu_data_in, ppu_scaling_factor);
  assign mux_out      = ppu_relu_sel ? q_cur : pool_reg;
  assign ppu_data_out = (ppu_relu_en && mux_out[7]) ? 8'h00 : mux_out;

  always @(posedge clk) begin
    if (ppu_maxpool_en) begin
      if (ppu_maxpool_init || ($signed(q_cur) > $signed(pool_reg))) pool_reg <= q_cur;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          pool;
    bit          relu;
    logic [5:0]  scale;
    logic [2:0]  win;
    int          num;
    int          np;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  int   ps_tab [NV][12];

  // Run one table job: optional input gaps, optional out_ready hold on the
  // first word (with a stray start pulse that must be ignored).
  task automatic run_job(input int v, input bit gaps, input int hold);
    int idx, nw, cyc, held, n_init, n_en;
    bit done_seen, released;
    logic [31:0] expw;
    idx = 0; nw = 0; cyc = 0; held = 0; n_init = 0; n_en = 0;
    done_seen = 0; released = 0;
    @(negedge clk);
    cfg_pool_en = vecs[v].pool;
    cfg_relu_en = vecs[v].relu;
    cfg_scale   = vecs[v].scale;
    cfg_win_len = vecs[v].win;
    cfg_num_out = 16'(vecs[v].num);
    start = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d relu_sel", v), 32'(ppu_relu_sel), 32'(!vecs[v].pool));
    check($sformatf("v%0d relu_en", v), 32'(ppu_relu_en), 32'(vecs[v].relu));
    check($sformatf("v%0d scale", v), 32'(ppu_scaling_factor), 32'(vecs[v].scale));
    while (!done_seen && cyc < 3000) begin
      start = 1'b0;
      if (released) begin
        check($sformatf("v%0d valid_drop_after_release", v), 32'(out_valid), 32'd0);
        released = 0;
      end
      if (ppu_maxpool_init) n_init++;
      if (ppu_maxpool_en) n_en++;
      if (done) done_seen = 1;
      expw = (nw == 0) ? vecs[v].w0 : vecs[v].w1;
      if (out_valid) begin
        if (!out_ready) begin
          held++;
          check($sformatf("v%0d hold_data", v), out_data, expw);
          check($sformatf("v%0d hold_in_ready", v), 32'(in_ready), 32'd0);
          if (held == 5) start = 1'b1;
          if (held >= hold) begin
            out_ready = 1'b1;
            released = 1;
          end
        end
        if (out_ready) begin
          check($sformatf("v%0d word%0d", v, nw), out_data, expw);
          nw++;
        end
      end
      if (idx < vecs[v].np && (!gaps || (cyc % 2 == 0))) begin
        in_valid = 1'b1;
        in_data  = 16'(ps_tab[v][idx]);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("v%0d done_seen", v), 32'(done_seen), 32'd1);
    check($sformatf("v%0d words", v), 32'(nw), 32'(vecs[v].nw));
    check($sformatf("v%0d psums_taken", v), 32'(idx), 32'(vecs[v].np));
    check($sformatf("v%0d init_pulses", v), 32'(n_init), 32'(vecs[v].num));
    check($sformatf("v%0d en_pulses", v), 32'(n_en), vecs[v].pool ? 32'(vecs[v].np) : 32'd0);
    check($sformatf("v%0d done_one_cycle", v), 32'({done, busy}), 32'd0);
    $display("job v%0d gaps=%0d hold=%0d: %0d words, %0d psums", v, gaps, hold, nw, idx);
  endtask

  initial begin
    int hs;
    vecs[0] = '{pool:1'b0, relu:1'b0, scale:6'd0, win:3'd1, num:4, np:4,  nw:1, w0:32'h281E140A, w1:32'h0};
    vecs[1] = '{pool:1'b1, relu:1'b0, scale:6'd0, win:3'd4, num:1, np:4,  nw:1, w0:32'h00000009, w1:32'h0};
    vecs[2] = '{pool:1'b1, relu:1'b0, scale:6'd0, win:3'd2, num:6, np:12, nw:2, w0:32'h64FB0702, w1:32'h00000604};
    vecs[3] = '{pool:1'b0, relu:1'b1, scale:6'd2, win:3'd1, num:3, np:3,  nw:1, w0:32'h007F0064, w1:32'h0};
    vecs[4] = '{pool:1'b1, relu:1'b0, scale:6'd0, win:3'd0, num:2, np:2,  nw:1, w0:32'h00000403, w1:32'h0};
    vecs[5] = '{pool:1'b0, relu:1'b0, scale:6'd0, win:3'd1, num:0, np:0,  nw:0, w0:32'h0,        w1:32'h0};
    vecs[6] = '{pool:1'b1, relu:1'b0, scale:6'd0, win:3'd3, num:2, np:6,  nw:1, w0:32'h00000CFE, w1:32'h0};
    ps_tab[0] = '{10, 20, 30, 40, 0, 0, 0, 0, 0, 0, 0, 0};
    ps_tab[1] = '{5, -3, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    ps_tab[2] = '{1, 2, 7, 3, -5, -9, 100, 50, 4, 4, -1, 6};
    ps_tab[3] = '{400, -40, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ps_tab[4] = '{3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ps_tab[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ps_tab[6] = '{-7, -2, -30, 12, -100, 11, 0, 0, 0, 0, 0, 0};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_win_len = '0; cfg_pool_en = 1'b0; cfg_relu_en = 1'b0; cfg_scale = '0; cfg_num_out = '0;
    pool_reg = '0;
    repeat (3) @(negedge clk);
    check("reset ctrl", 32'({in_ready, out_valid, busy, done, ppu_maxpool_en, ppu_maxpool_init,
                             ppu_relu_sel, ppu_relu_en, ppu_scaling_factor}), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset ppu_data_in", 32'(ppu_data_in), 32'd0);
    rst = 1'b1;

    for (int v = 0; v < NV; v++) run_job(v, 1'b0, 0);

    run_job(1, 1'b1, 0);
    run_job(2, 1'b1, 0);
    run_job(0, 1'b0, 10);
    run_job(2, 1'b0, 10);

    // Reset in FEED with two bytes already packed.
    @(negedge clk);
    cfg_pool_en = 1'b0; cfg_relu_en = 1'b0; cfg_scale = '0; cfg_win_len = 3'd1; cfg_num_out = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      in_valid = 1'b1;
      in_data  = (hs == 0) ? 16'd50 : 16'd60;
      if (in_ready) hs++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst in_ready", 32'(in_ready), 32'd1);
    check("pre_rst partial", out_data, 32'h00003C32);
    #2 rst = 1'b0;
    #1;
    check("mid_rst ctrl", 32'({in_ready, out_valid, busy, done, ppu_maxpool_en, ppu_maxpool_init,
                               ppu_relu_sel, ppu_relu_en, ppu_scaling_factor}), 32'd0);
    check("mid_rst out_data", out_data, 32'd0);
    check("mid_rst ppu_data_in", 32'(ppu_data_in), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_job(0, 1'b0, 0);
    run_job(6, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
